// File: rtl/uwasic_spi_pwm_peripheral.sv
// uwasic_spi_pwm_peripheral: write-only SPI slave with a 5-register file driving 16 outputs (off/on/shared PWM); ports clk, rst_n, ena, ui_in{nCS,COPI,SCLK}, uio_in, uo_out[7:0], uio_out[15:8], uio_oe=FF
module uwasic_spi_pwm_peripheral #(
  parameter int CLK_DIV = 13
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  localparam int PW = $clog2(CLK_DIV);
  logic [2:0] s1, s2, s3;
  logic [15:0] shift, en_out, en_pwm, outs;
  logic [4:0] cnt;
  logic done, wr, pwm;
  logic [7:0] duty, pwm_cnt;
  logic [PW-1:0] psc;
  logic sclk_rise, ncs_fall, ncs_rise;
  logic unused;
  assign unused = &{ena, uio_in, ui_in[7:3], 1'b0};
  assign sclk_rise = s2[0] & ~s3[0];
  assign ncs_fall = ~s2[2] & s3[2];
  assign ncs_rise = s2[2] & ~s3[2];
  assign wr = done && cnt == 5'd16 && shift[15] && shift[14:8] <= 7'h04;
  assign pwm = duty == 8'hFF || pwm_cnt < duty;
  assign uo_out = outs[7:0];
  assign uio_out = outs[15:8];
  assign uio_oe = 8'hFF;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {s1, s2, s3} <= '0;
      shift <= '0;
      cnt <= '0;
      done <= 1'b0;
      en_out <= '0;
      en_pwm <= '0;
      duty <= '0;
      psc <= '0;
      pwm_cnt <= '0;
      outs <= '0;
    end else begin
      s1 <= ui_in[2:0];
      s2 <= s1;
      s3 <= s2;
      done <= ncs_rise;
      if (ncs_fall) begin
        shift <= '0;
        cnt <= '0;
      end else if (!s2[2] && sclk_rise) begin
        shift <= {shift[14:0], s2[1]};
        cnt <= cnt == 5'd31 ? cnt : cnt + 5'd1;
      end
      if (wr && shift[14:8] == 7'h00) en_out[7:0] <= shift[7:0];
      if (wr && shift[14:8] == 7'h01) en_out[15:8] <= shift[7:0];
      if (wr && shift[14:8] == 7'h02) en_pwm[7:0] <= shift[7:0];
      if (wr && shift[14:8] == 7'h03) en_pwm[15:8] <= shift[7:0];
      if (wr && shift[14:8] == 7'h04) duty <= shift[7:0];
      psc <= psc == PW'(CLK_DIV - 1) ? '0 : psc + 1'b1;
      if (psc == PW'(CLK_DIV - 1)) pwm_cnt <= pwm_cnt + 8'd1;
      outs <= en_out & (~en_pwm | {16{pwm}});
    end
  end
endmodule

// File: tb/tb_uwasic_spi_pwm_peripheral.sv
// tb_uwasic_spi_pwm_peripheral: directed self-checking bench for the SPI PWM peripheral
module tb_uwasic_spi_pwm_peripheral;
  logic clk = 1'b0;
  logic rst_n;
  logic ena = 1'b1;
  logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;
  int checks = 0;
  int failures = 0;
  uwasic_spi_pwm_peripheral dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );
  always #50 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic spi(input logic [15:0] d, input int n);
    logic [31:0] bits;
    bits = {d, 16'h0000};
    ui_in[2] = 1'b0;
    cycles(4);
    for (int i = 0; i < n; i++) begin
      ui_in[0] = 1'b0;
      ui_in[1] = bits[31 - i];
      cycles(4);
      ui_in[0] = 1'b1;
      cycles(4);
    end
    ui_in[0] = 1'b0;
    cycles(4);
    ui_in[2] = 1'b1;
    cycles(12);
  endtask
  task automatic measure(output int len, output int hi);
    logic prev;
    bit found;
    found = 0;
    len = 0;
    hi = 0;
    prev = uo_out[0];
    for (int i = 0; i < 5000 && !found; i++) begin
      cycles(1);
      found = !prev && uo_out[0];
      prev = uo_out[0];
    end
    if (!found) return;
    hi = 1;
    for (int i = 0; i < 5000; i++) begin
      cycles(1);
      len++;
      if (!prev && uo_out[0]) return;
      prev = uo_out[0];
      if (uo_out[0]) hi++;
    end
  endtask
  task automatic count_ones(input int n, output int ones);
    ones = 0;
    for (int i = 0; i < n; i++) begin
      cycles(1);
      if (uo_out[0]) ones++;
    end
  endtask
  initial begin
    int len, hi, ones;
    rst_n = 1'b0;
    ui_in = 8'h04;
    uio_in = 8'h00;
    cycles(3);
    check("reset_uo", {8'h00, uo_out}, 16'h0000);
    check("reset_uio", {8'h00, uio_out}, 16'h0000);
    check("reset_oe", {8'h00, uio_oe}, 16'h00FF);
    rst_n = 1'b1;
    cycles(20);
    check("post_reset_uo", {uio_out, uo_out}, 16'h0000);
    for (int i = 0; i < 6; i++) begin
      ui_in[0] = ~ui_in[0];
      cycles(4);
    end
    check("sclk_no_cs", {uio_out, uo_out}, 16'h0000);
    spi(16'h80F0, 16);
    check("wr_en_lo", {8'h00, uo_out}, 16'h00F0);
    spi(16'h81CC, 16);
    check("wr_en_hi", {uio_out, uo_out}, 16'hCCF0);
    spi(16'h0030, 16);
    check("read_dropped", {uio_out, uo_out}, 16'hCCF0);
    spi(16'hB0AA, 16);
    check("bad_addr30", {uio_out, uo_out}, 16'hCCF0);
    spi(16'h8500, 16);
    check("bad_addr05", {uio_out, uo_out}, 16'hCCF0);
    spi(16'h8001, 16);
    spi(16'h8201, 16);
    check("pwm_duty0", {uio_out, uo_out}, 16'hCC00);
    spi(16'h8480, 16);
    measure(len, hi);
    check("pwm_period", len[15:0], 16'd3328);
    check("pwm_high", hi[15:0], 16'd1664);
    spi(16'h8440, 16);
    measure(len, hi);
    check("pwm40_period", len[15:0], 16'd3328);
    check("pwm40_high", hi[15:0], 16'd832);
    spi(16'h8400, 16);
    count_ones(4000, ones);
    check("duty00_ones", ones[15:0], 16'd0);
    spi(16'h84FF, 16);
    count_ones(4000, ones);
    check("dutyFF_ones", ones[15:0], 16'd4000);
    spi(16'h8000, 15);
    check("short_dropped", {uio_out, uo_out}, 16'hCC01);
    spi(16'h8000, 17);
    check("long_dropped", {uio_out, uo_out}, 16'hCC01);
    spi(16'h8000, 16);
    check("valid_after", {uio_out, uo_out}, 16'hCC00);
    ui_in[2] = 1'b0;
    cycles(4);
    for (int i = 0; i < 8; i++) begin
      ui_in[1] = 1'b1;
      ui_in[0] = 1'b0;
      cycles(4);
      ui_in[0] = 1'b1;
      cycles(4);
    end
    #20 rst_n = 1'b0;
    #1 check("async_reset", {uio_out, uo_out}, 16'h0000);
    cycles(2);
    ui_in = 8'h04;
    rst_n = 1'b1;
    cycles(20);
    check("midframe_discard", {uio_out, uo_out}, 16'h0000);
    spi(16'h8155, 16);
    check("after_reset_wr", {uio_out, uo_out}, 16'h5500);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
